plot_arbiter: RTL and testbench

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/plot_arb_pkg.sv | 21 ++
 rtl/plot_arb_prio.sv | 31 +++
 rtl/plot_arbiter.sv | 179 +++++++++++++++++
 tb/tb_plot_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/plot_arb_pkg.sv
// Shared constants, widths and state encoding for the VGA plot-port arbiter.
package plot_arb_pkg;

  localparam int N_REQ = 4;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;

  localparam int REQ_CLEAR  = 0;
  localparam int REQ_GRID   = 1;
  localparam int REQ_NUM    = 2;
  localparam int REQ_BANNER = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/plot_arb_prio.sv
// Fixed-priority encoder: lowest set request index wins, reported as one-hot and as an index.
module plot_arb_prio #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic found_s;

  // Scan upward so the first set bit found is the highest-priority one.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    any_o   = |req_i;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found_s) begin
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the VGA plot port among N_REQ drawing engines (IDLE/GRANT/BUSY/RELEASE).
// Optional BUSY watchdog enabled by defining PLOT_ARB_WDT_EN.
module plot_arbiter
  import plot_arb_pkg::*;
#(
  parameter int N_REQ = plot_arb_pkg::N_REQ
`ifdef PLOT_ARB_WDT_EN
  , parameter int TIMEOUT = 32768
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       done,
  input  logic [X_W*N_REQ-1:0]   x_in,
  input  logic [Y_W*N_REQ-1:0]   y_in,
  input  logic [C_W*N_REQ-1:0]   col_in,
  input  logic [N_REQ-1:0]       plot_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   writeEn,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d, prio_idx_s;
  logic [N_REQ-1:0]   win_oh_q, win_oh_d, prio_oh_s;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [C_W-1:0]     col_q, col_d;
  logic               we_q, we_d;
  logic               prio_any_s;
  logic               holder_plot_s;
  logic               holder_done_s;
  logic               wdt_fire_s;

  plot_arb_prio #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req_i (req),
    .gnt_o (prio_oh_s),
    .idx_o (prio_idx_s),
    .any_o (prio_any_s)
  );

  assign holder_plot_s = plot_in[win_q];
  assign holder_done_s = done[win_q];

  // State and captured-winner registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      win_oh_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      win_oh_q <= win_oh_d;
    end
  end

  // Next-state logic; the winner is only re-captured in IDLE, so late requests wait.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    win_oh_d = win_oh_q;
    case (state_q)
      ST_IDLE: begin
        if (prio_any_s) begin
          state_d  = ST_GRANT;
          win_d    = prio_idx_s;
          win_oh_d = prio_oh_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_GRANT:   state_d = ST_BUSY;
      ST_BUSY: begin
        if (holder_done_s || wdt_fire_s) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode; pixels are only taken from the holder while BUSY.
  always_comb begin
    gnt_d = '0;
    we_d  = 1'b0;
    x_d   = x_q;
    y_d   = y_q;
    col_d = col_q;
    if ((state_d == ST_GRANT) || (state_d == ST_BUSY)) begin
      gnt_d = win_oh_d;
    end else begin
      gnt_d = '0;
    end
    if ((state_q == ST_BUSY) && holder_plot_s) begin
      we_d  = 1'b1;
      x_d   = x_in[win_q*X_W +: X_W];
      y_d   = y_in[win_q*Y_W +: Y_W];
      col_d = col_in[win_q*C_W +: C_W];
    end else begin
      we_d  = 1'b0;
    end
  end

  // Registered grant and pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q <= '0;
      we_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      col_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      we_q  <= we_d;
      x_q   <= x_d;
      y_q   <= y_d;
      col_q <= col_d;
    end
  end

`ifdef PLOT_ARB_WDT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wdt_q;
  logic             terr_q;

  assign wdt_fire_s = (state_q == ST_BUSY) && !holder_done_s &&
                      (wdt_q == CNT_W'(TIMEOUT - 1));

  // BUSY-cycle counter, cleared while granting; timeout flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == ST_GRANT) begin
        wdt_q <= '0;
      end else if (state_q == ST_BUSY) begin
        wdt_q <= wdt_q + CNT_W'(1);
      end else begin
        wdt_q <= wdt_q;
      end
      if (wdt_fire_s) begin
        terr_q <= 1'b1;
      end else begin
        terr_q <= terr_q;
      end
    end
  end

  assign timeout_err = terr_q;
`else
  assign wdt_fire_s  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign writeEn = we_q;
  assign x       = x_q;
  assign y       = y_q;
  assign colour  = col_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: a per-cycle reference model pushes expectations,
// a negedge monitor pops and compares. Define PLOT_ARB_WDT_EN to exercise the watchdog.
module tb_plot_arbiter;

  localparam int N          = 4;
  localparam int TB_TIMEOUT = 16;
  localparam int P_IDLE     = 0;
  localparam int P_GRANT    = 1;
  localparam int P_BUSY     = 2;
  localparam int P_RELEASE  = 3;
`ifdef PLOT_ARB_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] req, done, plot_in;
  logic [8*N-1:0] x_in;
  logic [7*N-1:0] y_in;
  logic [3*N-1:0] col_in;
  logic [N-1:0] gnt;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic         writeEn, busy, timeout_err;

`ifdef PLOT_ARB_WDT_EN
  plot_arbiter #(.N_REQ(N), .TIMEOUT(TB_TIMEOUT)) dut (
`else
  plot_arbiter #(.N_REQ(N)) dut (
`endif
    .clk(clk), .reset(reset), .req(req), .done(done),
    .x_in(x_in), .y_in(y_in), .col_in(col_in), .plot_in(plot_in),
    .gnt(gnt), .x(x), .y(y), .colour(colour),
    .writeEn(writeEn), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic       busy;
    logic       we;
    logic       terr;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state, in terms of the spec's phases and counts.
  int         m_phase = P_IDLE;
  int         m_holder = 0;
  int         m_busy_cycles = 0;
  logic       m_we = 1'b0, m_terr = 1'b0;
  logic [7:0] m_x = 8'd0;
  logic [6:0] m_y = 7'd0;
  logic [2:0] m_c = 3'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lowest_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    exp_t e;
    if (reset) begin
      m_phase = P_IDLE; m_holder = 0; m_busy_cycles = 0;
      m_we = 1'b0; m_terr = 1'b0; m_x = 8'd0; m_y = 7'd0; m_c = 3'd0;
    end else begin
      m_we = (m_phase == P_BUSY) && plot_in[m_holder];
      if (m_we) begin
        m_x = x_in[8*m_holder +: 8];
        m_y = y_in[7*m_holder +: 7];
        m_c = col_in[3*m_holder +: 3];
      end
      case (m_phase)
        P_IDLE: if (req != 4'b0000) begin m_holder = lowest_set(req); m_phase = P_GRANT; end
        P_GRANT: begin m_phase = P_BUSY; m_busy_cycles = 0; end
        P_BUSY: begin
          m_busy_cycles++;
          if (done[m_holder]) m_phase = P_RELEASE;
          else if (WDT_ON && m_busy_cycles == TB_TIMEOUT) begin
            m_phase = P_RELEASE; m_terr = 1'b1;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
    e.gnt  = (m_phase == P_GRANT || m_phase == P_BUSY) ? (4'b0001 << m_holder) : 4'b0000;
    e.busy = (m_phase != P_IDLE);
    e.we   = m_we;
    e.terr = m_terr;
    e.x    = m_x;
    e.y    = m_y;
    e.c    = m_c;
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every output cycle is checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("gnt", gnt, e.gnt);
        chk("busy", busy, e.busy);
        chk("writeEn", writeEn, e.we);
        chk("x", x, e.x);
        chk("y", y, e.y);
        chk("colour", colour, e.c);
        chk("timeout_err", timeout_err, e.terr);
      end
    end
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic [3:0] p);
    req = r; done = d; plot_in = p;
    @(negedge clk);
  endtask

  task automatic set_pix(input int i, input logic [7:0] xv, input logic [6:0] yv, input logic [2:0] cv);
    x_in[8*i +: 8]   = xv;
    y_in[7*i +: 7]   = yv;
    col_in[3*i +: 3] = cv;
  endtask

  task automatic rand_pix();
    x_in   = {$urandom, $urandom};
    y_in   = 28'($urandom);
    col_in = 12'($urandom);
  endtask

  initial begin
    logic [3:0] rd;
    reset = 1'b1; req = '0; done = '0; plot_in = '0;
    x_in = '0; y_in = '0; col_in = '0;
    @(negedge clk);
    cyc(4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;

    // Two simultaneous requests: engine 1 wins, plots (5,3,7), engine 2 follows.
    cyc(4'b0110, 4'b0000, 4'b0000);
    cyc(4'b0110, 4'b0000, 4'b0000);
    set_pix(1, 8'd5, 7'd3, 3'd7);
    set_pix(2, 8'd99, 7'd99, 3'd1);
    cyc(4'b0110, 4'b0000, 4'b0110);
    cyc(4'b0110, 4'b0010, 4'b0000);
    cyc(4'b0100, 4'b0000, 4'b0000);
    cyc(4'b0100, 4'b0000, 4'b0000);
    // Engine 2 holds; engine 0 requests, plots x=99 and pulses done, all ignored.
    cyc(4'b0101, 4'b0000, 4'b0000);
    set_pix(0, 8'd99, 7'd10, 3'd2);
    repeat (3) cyc(4'b0101, 4'b0001, 4'b0001);
    cyc(4'b0001, 4'b0000, 4'b0000);
    // Holder done together with its last pixel.
    set_pix(2, 8'd42, 7'd17, 3'd5);
    cyc(4'b0001, 4'b0100, 4'b0100);
    cyc(4'b0001, 4'b0000, 4'b0000);
    cyc(4'b0001, 4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000, 4'b0000);
    // Engine 0 draws for ten BUSY cycles, then reset mid-drawing.
    for (int i = 0; i < 10; i++) begin
      rand_pix();
      cyc(4'b0000, 4'b0000, 4'b0001);
    end
    reset = 1'b1;
    cyc(4'b0001, 4'b0000, 4'b0001);
    reset = 1'b0;
    cyc(4'b0000, 4'b0000, 4'b0000);

`ifdef PLOT_ARB_WDT_EN
    // Engine 3 never signals done: watchdog forces release; flag stays until reset.
    cyc(4'b1000, 4'b0000, 4'b0000);
    for (int i = 0; i < 30; i++) begin
      rand_pix();
      cyc(4'b0000, 4'b0000, 4'($urandom));
    end
    reset = 1'b1;
    cyc(4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rand_pix();
      for (int i = 0; i < N; i++) rd[i] = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 399) == 0);
      cyc(4'($urandom), rd, 4'($urandom));
    end
    reset = 1'b0;
    repeat (4) cyc(4'b0000, 4'b0000, 4'b0000);
    #2;
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
